id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- Pipeline register between ID and EX in the 5-stage RV32I core.
- Captures decoded operands and the ALU-control decode (ALUControl, BranchOp, SLTc) plus datapath controls, and presents them registered to EX.
- Owns load-use hazard detection: inserts a one-cycle bubble and stalls IF/ID.
- Honours an external hold (stall) and a branch-resolution flush from EX.

Parameters:
- XLEN, 32, datapath/operand width
- REGW, 5, register index width
- CNTW, 16, width of optional performance counters

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_data  in  XLEN  register-file read port 1
- id_rs2_data  in  XLEN  register-file read port 2
- id_imm  in  XLEN  sign-extended immediate
- id_rs1  in  REGW  source index 1
- id_rs2  in  REGW  source index 2
- id_rd  in  REGW  destination index
- id_alu_control  in  3  ALU operation code from ALU control decode
- id_branch_op  in  2  branch compare class from ALU control decode
- id_sltc  in  1  set-less-than select from ALU control decode
- id_alu_src  in  1  1 = immediate operand B
- id_reg_write  in  1  writes rd
- id_mem_read  in  1  load
- id_mem_write  in  1  store
- id_mem_to_reg  in  1  writeback from memory
- hold  in  1  downstream stall, freeze register
- flush  in  1  taken branch/jump resolved in EX, kill ID instruction
- id_stall  out  1  combinational, freeze PC and IF/ID
- ex_valid  out  1  EX instruction is real
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  REGW  registered copies
- ex_alu_control  out  3  registered copy
- ex_branch_op  out  2  registered copy
- ex_sltc, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered copies

Behaviour:
- Reset: every ex_* output = 0, hazard FSM = RUN, id_stall = 0.
- Latency: one cycle from ID input to ex_* output.
- Load-use detection (combinational):
  - lu = ex_valid & ex_mem_read & ex_rd != 0 & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2)
  - id_stall = (lu & FSM==RUN & !flush) | hold
- Per-edge update priority: rst > flush > hold > lu bubble > normal load.
  - flush: ex_valid and all control bits (reg_write, mem_read, mem_write, mem_to_reg, alu_src, sltc, branch_op, alu_control) cleared to 0; data/index fields hold; FSM -> RUN. flush wins over simultaneous hold.
  - hold: every register keeps its value; FSM unchanged.
  - bubble: same clearing as flush; data/index fields hold; FSM RUN -> BUBBLE.
  - normal: all fields load from id_*; ex_valid = id_valid; FSM -> RUN.
  - id_valid = 0 on a normal load: controls are still loaded as presented. EX qualifies every control bit with ex_valid.
- Hazard FSM:
  - RUN -> BUBBLE on lu without flush or hold.
  - BUBBLE -> RUN on the next non-hold edge.
  - In BUBBLE, lu is masked, so at most one bubble is inserted per load.
- x0: ex_rd == 0 never causes a hazard.
- Mid-operation reset: rst in BUBBLE returns to RUN with outputs cleared the same cycle.

Optional Feature:
- Macro: ID_EX_PERF_COUNTERS_EN
- Defined:
  - Adds outputs bubble_cnt[CNTW] and flush_cnt[CNTW].
  - bubble_cnt increments on each inserted bubble; flush_cnt increments on each flush edge.
  - Both saturate at all-ones and clear on rst.
- Undefined: no ports, no counter logic.

Decomposition:
- Shared package core_pkg:
  - ALU op encodings (ADD=000, SUB/SLT=001, SLL=010, SLTU=011, SRL/SRA=100, XOR=101, OR=110, AND=111)
  - BranchOp encodings (00 none, 01 ne, 10 eq/lt, 11 ge)
  - XLEN/REGW constants
  - FSM state enum {RUN, BUBBLE}
- Sub-module hazard_unit: lu compare plus FSM, outputs bubble and id_stall. The register bank stays in id_ex_pipe.

Test Plan:
- Normal load: id_valid=1, id_alu_control=3'b101, id_rd=7, id_reg_write=1 -> next edge ex_alu_control=101, ex_rd=7, ex_reg_write=1, ex_valid=1.
- Load-use: EX holds lw with ex_rd=5; ID presents id_rs2=5 -> id_stall=1 that cycle; next edge ex_valid=0, ex_reg_write=0; next cycle id_stall=0 and the add loads.
- x0 load: ex_mem_read=1, ex_rd=0, id_rs1=0 -> id_stall=0, no bubble.
- Flush+hold same cycle: ex_valid=1, flush=1, hold=1 -> next edge ex_valid=0, all controls 0.
- Hold: hold=1 for 3 cycles with changing id_* -> ex_* unchanged; release -> loads current id_*.
- Reset in BUBBLE: rst=1 -> all outputs 0, FSM=RUN; with macro defined, counters read 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: operand widths, ALU/branch
// decode encodings and the load-use hazard FSM state type.
package core_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int CNTW = 16;

    // ALU operation codes produced by the ALU control decode
    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_SRL  = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

    // Branch compare classes
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_NE   = 2'b01,
        BR_EQLT = 2'b10,
        BR_GE   = 2'b11
    } branch_op_e;

    // Load-use hazard FSM: RUN normally, BUBBLE for the cycle after a bubble
    typedef enum logic {
        HZ_RUN    = 1'b0,
        HZ_BUBBLE = 1'b1
    } hz_state_e;

endpackage

// File: rtl/id_ex_pipe_hazard_unit.sv
// Load-use hazard detection for the ID/EX boundary. Compares the load in EX
// against the ID sources and inserts at most one bubble per load.
module hazard_unit
    import core_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic [REGW-1:0] ex_rd,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            hold,
    input  logic            flush,
    output logic            bubble,
    output logic            id_stall
);

    hz_state_e state;
    hz_state_e state_next;
    logic      lu;

    // State register; reset always returns to RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HZ_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Hazard compare, stall request and next state; x0 never hazards
    always_comb begin
        state_next = state;
        bubble     = 1'b0;
        lu         = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        id_stall   = hold || (lu && (state == HZ_RUN) && !flush);
        if (flush) begin
            state_next = HZ_RUN;
        end else if (hold) begin
            state_next = state;
        end else if (lu && (state == HZ_RUN)) begin
            state_next = HZ_BUBBLE;
            bubble     = 1'b1;
        end else begin
            state_next = HZ_RUN;
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, hold and flush.
// Optional saturating bubble/flush counters when ID_EX_PERF_COUNTERS_EN is defined.
module id_ex_pipe
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN,
    parameter int REGW = core_pkg::REGW,
    parameter int CNTW = core_pkg::CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [2:0]      id_alu_control,
    input  logic [1:0]      id_branch_op,
    input  logic            id_sltc,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            hold,
    input  logic            flush,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [REGW-1:0] ex_rs1,
    output logic [REGW-1:0] ex_rs2,
    output logic [REGW-1:0] ex_rd,
    output logic [2:0]      ex_alu_control,
    output logic [1:0]      ex_branch_op,
    output logic            ex_sltc,
    output logic            ex_alu_src,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
`ifdef ID_EX_PERF_COUNTERS_EN
    output logic            ex_mem_to_reg,
    output logic [CNTW-1:0] bubble_cnt,
    output logic [CNTW-1:0] flush_cnt
`else
    output logic            ex_mem_to_reg
`endif
);

    logic bubble;

    hazard_unit #(.REGW(REGW)) u_hazard (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_mem_read(ex_mem_read),
        .ex_rd      (ex_rd),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .hold       (hold),
        .flush      (flush),
        .bubble     (bubble),
        .id_stall   (id_stall)
    );

    // Register bank: flush or bubble kill controls but keep data, hold freezes all
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid       <= 1'b0;
            ex_pc          <= '0;
            ex_rs1_data    <= '0;
            ex_rs2_data    <= '0;
            ex_imm         <= '0;
            ex_rs1         <= '0;
            ex_rs2         <= '0;
            ex_rd          <= '0;
            ex_alu_control <= '0;
            ex_branch_op   <= '0;
            ex_sltc        <= 1'b0;
            ex_alu_src     <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
        end else if (flush || bubble) begin
            ex_valid       <= 1'b0;
            ex_alu_control <= '0;
            ex_branch_op   <= '0;
            ex_sltc        <= 1'b0;
            ex_alu_src     <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
        end else if (!hold) begin
            ex_valid       <= id_valid;
            ex_pc          <= id_pc;
            ex_rs1_data    <= id_rs1_data;
            ex_rs2_data    <= id_rs2_data;
            ex_imm         <= id_imm;
            ex_rs1         <= id_rs1;
            ex_rs2         <= id_rs2;
            ex_rd          <= id_rd;
            ex_alu_control <= id_alu_control;
            ex_branch_op   <= id_branch_op;
            ex_sltc        <= id_sltc;
            ex_alu_src     <= id_alu_src;
            ex_reg_write   <= id_reg_write;
            ex_mem_read    <= id_mem_read;
            ex_mem_write   <= id_mem_write;
            ex_mem_to_reg  <= id_mem_to_reg;
        end
    end

`ifdef ID_EX_PERF_COUNTERS_EN
    // Saturating counters of inserted bubbles and flush edges
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (bubble && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: directed vectors push expected stall and
// registered EX state; an independent monitor pops and compares each cycle.
module tb_id_ex_pipe;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  aluc;
        logic [1:0]  br;
        logic        sltc;
        logic        alusrc;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
    } fields_t;

    typedef struct packed {
        logic    stall;
        fields_t f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, hold, flush;
    logic        id_valid, id_sltc, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_alu_control;
    logic [1:0]  id_branch_op;
    logic        id_stall, ex_valid, ex_sltc, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_alu_control;
    logic [1:0]  ex_branch_op;
`ifdef ID_EX_PERF_COUNTERS_EN
    logic [15:0] bubble_cnt, flush_cnt;
`endif

    fields_t act;
    exp_t    sb[$];
    int      total = 0;
    int      bad = 0;

    always #5 clk = ~clk;

    assign act = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                  ex_alu_control, ex_branch_op, ex_sltc, ex_alu_src, ex_reg_write,
                  ex_mem_read, ex_mem_write, ex_mem_to_reg};

    id_ex_pipe dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_control(id_alu_control), .id_branch_op(id_branch_op), .id_sltc(id_sltc),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .hold(hold), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alu_control(ex_alu_control), .ex_branch_op(ex_branch_op), .ex_sltc(ex_sltc),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write),
`ifdef ID_EX_PERF_COUNTERS_EN
        .ex_mem_to_reg(ex_mem_to_reg), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`else
        .ex_mem_to_reg(ex_mem_to_reg)
`endif
    );

    function automatic fields_t mk(input logic v, input logic [31:0] pc, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] imm,
                                   input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                   input logic [2:0] aluc, input logic [1:0] br, input logic sltc,
                                   input logic alusrc, input logic rw, input logic mr,
                                   input logic mw, input logic m2r);
        fields_t f;
        f = {v, pc, a, b, imm, rs1, rs2, rd, aluc, br, sltc, alusrc, rw, mr, mw, m2r};
        return f;
    endfunction

    // A bubble or flush keeps data/index fields and zeroes valid and controls
    function automatic fields_t kill(input fields_t f);
        fields_t k;
        k        = f;
        k.valid  = 1'b0;
        k.aluc   = 3'b000;
        k.br     = 2'b00;
        k.sltc   = 1'b0;
        k.alusrc = 1'b0;
        k.rw     = 1'b0;
        k.mr     = 1'b0;
        k.mw     = 1'b0;
        k.m2r    = 1'b0;
        return k;
    endfunction

    task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic driveInputs(input logic r, input logic h, input logic fl, input fields_t v);
        rst = r; hold = h; flush = fl;
        {id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
         id_alu_control, id_branch_op, id_sltc, id_alu_src, id_reg_write,
         id_mem_read, id_mem_write, id_mem_to_reg} = v;
    endtask

    task automatic applyStimulus(input logic r, input logic h, input logic fl, input fields_t v,
                                 input logic exp_stall, input fields_t exp_f);
        exp_t e;
        @(posedge clk);
        #2;
        driveInputs(r, h, fl, v);
        e.stall = exp_stall;
        e.f     = exp_f;
        sb.push_back(e);
    endtask

    // Monitor: stall is checked mid-cycle, registered outputs just after the edge
    initial begin
        forever begin
            wait (sb.size() > 0);
            @(negedge clk);
            checkOutput("id_stall", {159'd0, id_stall}, {159'd0, sb[0].stall});
            @(posedge clk);
            #1;
            checkOutput("ex_regs", {5'd0, act}, {5'd0, sb[0].f});
            void'(sb.pop_front());
        end
    end

    initial begin
        fields_t zero, i0, ld, a, x0l, b, c1, c2, c3, d, e, f, l2, g, l3, h, l4, h2, l5, v0, l6, j;
        zero = '0;
        i0  = mk(1, 32'h100, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd7, 3'b101, 2'b00, 0, 0, 1, 0, 0, 0);
        ld  = mk(1, 32'h104, 32'h1000, 32'h0, 32'h8, 5'd3, 5'd0, 5'd5, 3'b000, 2'b00, 0, 1, 1, 1, 0, 1);
        a   = mk(1, 32'h108, 32'h66, 32'h55, 32'h0, 5'd6, 5'd5, 5'd9, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0);
        x0l = mk(1, 32'h10c, 32'h2000, 32'h0, 32'h4, 5'd3, 5'd0, 5'd0, 3'b000, 2'b00, 0, 1, 1, 1, 0, 1);
        b   = mk(1, 32'h110, 32'h1, 32'h2, 32'h0, 5'd0, 5'd4, 5'd3, 3'b110, 2'b00, 0, 0, 1, 0, 0, 0);
        c1  = mk(1, 32'h114, 32'hA1, 32'hB1, 32'hC1, 5'd7, 5'd8, 5'd10, 3'b111, 2'b01, 0, 0, 0, 0, 0, 0);
        c2  = mk(1, 32'h118, 32'hA2, 32'hB2, 32'hC2, 5'd9, 5'd10, 5'd11, 3'b010, 2'b10, 1, 0, 1, 0, 0, 0);
        c3  = mk(1, 32'h11c, 32'hA3, 32'hB3, 32'hC3, 5'd11, 5'd12, 5'd13, 3'b011, 2'b11, 1, 1, 1, 0, 1, 0);
        d   = mk(1, 32'h120, 32'hD1, 32'hD2, 32'hD3, 5'd1, 5'd1, 5'd1, 3'b001, 2'b01, 0, 0, 1, 0, 0, 0);
        e   = mk(1, 32'h124, 32'hE1, 32'hE2, 32'hE3, 5'd14, 5'd15, 5'd16, 3'b100, 2'b01, 1, 1, 1, 0, 0, 0);
        f   = mk(1, 32'h128, 32'hF1, 32'hF2, 32'hF3, 5'd2, 5'd3, 5'd4, 3'b110, 2'b00, 0, 0, 1, 0, 0, 0);
        l2  = mk(1, 32'h128, 32'h3000, 32'h0, 32'hC, 5'd2, 5'd0, 5'd4, 3'b000, 2'b00, 0, 1, 1, 1, 0, 1);
        g   = mk(1, 32'h12c, 32'h44, 32'h45, 32'h0, 5'd4, 5'd1, 5'd17, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0);
        l3  = mk(1, 32'h130, 32'h3100, 32'h0, 32'h10, 5'd2, 5'd0, 5'd8, 3'b000, 2'b00, 0, 1, 1, 1, 0, 1);
        h   = mk(1, 32'h134, 32'h77, 32'h78, 32'h0, 5'd8, 5'd3, 5'd18, 3'b111, 2'b00, 0, 0, 1, 0, 0, 0);
        l4  = mk(1, 32'h138, 32'h3200, 32'h0, 32'h14, 5'd2, 5'd0, 5'd12, 3'b000, 2'b00, 0, 1, 1, 1, 0, 1);
        h2  = mk(1, 32'h13c, 32'h88, 32'h89, 32'h0, 5'd12, 5'd3, 5'd19, 3'b101, 2'b00, 0, 0, 1, 0, 0, 0);
        l5  = mk(1, 32'h140, 32'h3300, 32'h0, 32'h18, 5'd2, 5'd0, 5'd14, 3'b000, 2'b00, 0, 1, 1, 1, 0, 1);
        v0  = mk(0, 32'h144, 32'h99, 32'h9A, 32'h9B, 5'd14, 5'd0, 5'd13, 3'b010, 2'b00, 0, 0, 1, 0, 1, 0);
        l6  = mk(1, 32'h148, 32'h3400, 32'h0, 32'h1C, 5'd2, 5'd0, 5'd18, 3'b000, 2'b00, 0, 1, 1, 1, 0, 1);
        j   = mk(1, 32'h14c, 32'hAA, 32'hAB, 32'h0, 5'd5, 5'd18, 5'd20, 3'b110, 2'b00, 0, 0, 1, 0, 0, 0);

        driveInputs(1, 0, 0, zero);
        repeat (2) @(posedge clk);

        applyStimulus(1, 0, 0, i0,  0, zero);        // reset state
        applyStimulus(0, 0, 0, i0,  0, i0);          // normal load
        applyStimulus(0, 0, 0, ld,  0, ld);          // load into EX
        applyStimulus(0, 0, 0, a,   1, kill(ld));    // load-use on rs2 -> bubble
        applyStimulus(0, 0, 0, a,   0, a);           // dependent add loads
        applyStimulus(0, 0, 0, x0l, 0, x0l);         // load to x0
        applyStimulus(0, 0, 0, b,   0, b);           // rs1=x0 never hazards
        applyStimulus(0, 1, 0, c1,  1, b);           // hold three cycles
        applyStimulus(0, 1, 0, c2,  1, b);
        applyStimulus(0, 1, 0, c3,  1, b);
        applyStimulus(0, 0, 0, c3,  0, c3);          // release hold
        applyStimulus(0, 1, 1, d,   1, kill(c3));    // flush beats hold
        applyStimulus(0, 0, 0, e,   0, e);
        applyStimulus(0, 0, 1, f,   0, kill(e));     // flush alone
        applyStimulus(0, 0, 0, l2,  0, l2);
        applyStimulus(0, 0, 0, g,   1, kill(l2));    // bubble, FSM in BUBBLE
        applyStimulus(1, 0, 0, g,   0, zero);        // reset while in BUBBLE
        applyStimulus(0, 0, 0, l3,  0, l3);
        applyStimulus(0, 0, 0, h,   1, kill(l3));    // FSM back in RUN detects hazard
        applyStimulus(0, 0, 0, h,   0, h);
        applyStimulus(0, 0, 0, l4,  0, l4);
        applyStimulus(0, 1, 0, h2,  1, l4);          // hold beats bubble
        applyStimulus(0, 0, 0, h2,  1, kill(l4));
        applyStimulus(0, 0, 0, h2,  0, h2);
        applyStimulus(0, 0, 0, l5,  0, l5);
        applyStimulus(0, 0, 0, v0,  0, v0);          // id_valid=0: no hazard, controls loaded
        applyStimulus(0, 0, 0, l6,  0, l6);
        applyStimulus(0, 0, 1, j,   0, kill(l6));    // flush masks load-use stall
        applyStimulus(0, 0, 0, j,   0, j);

        begin : drain
            for (int k = 0; k < 20; k++) begin
                @(posedge clk);
                #3;
                if (sb.size() == 0) disable drain;
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain actual=%0d expected=0 pending entries", sb.size());
        end

`ifdef ID_EX_PERF_COUNTERS_EN
        checkOutput("bubble_cnt", {144'd0, bubble_cnt}, 160'd2);
        checkOutput("flush_cnt", {144'd0, flush_cnt}, 160'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
